decode_regfile: RTL
===================

// Module: decode_regfile
// PURPOSE
//  Integer register file at the Decode end of the writeback interface: absorbs the
//  registered write port driven by the Writeback stage (wr/rd/data) and serves two
//  registered read ports to Decode. Owns x0-is-zero semantics and post-reset clearing
//  of all architectural registers through a sequential init walk.
// PARAMETERS
//  DATA_W   `N (32)  register width
//  ADDR_W   5        register index width; depth = 2**ADDR_W
// PORTS
//  clk          in   1       single clock, rising edge
//  rst_n        in   1       asynchronous, active-low reset
//  i_rf_wr      in   1       write enable from Writeback
//  i_rf_rd      in   ADDR_W  destination register index from Writeback
//  i_rf_data    in   DATA_W  write data from Writeback
//  i_rd_req     in   1       Decode read request (valid)
//  i_rs1        in   ADDR_W  source index 1
//  i_rs2        in   ADDR_W  source index 2
//  i_stall      in   1       hold read outputs (Decode stalled)
//  o_rf_ready   out  1       high once init walk complete
//  o_rd_vld     out  1       read data valid, 1 cycle after accepted request
//  o_rs1_data   out  DATA_W  registered read data 1
//  o_rs2_data   out  DATA_W  registered read data 2
// BEHAVIOUR
//  Reset (async assert): o_rf_ready=0, o_rd_vld=0, o_rs1_data=0, o_rs2_data=0, FSM->INIT,
//   init counter=0. Array contents not reset directly (inferable as RAM).
//  FSM INIT: each cycle writes 0 to entry cnt, cnt++; on cnt==2**ADDR_W-1 -> READY
//   (exactly 2**ADDR_W cycles). o_rf_ready=1 registered on entry to READY.
//  FSM READY: terminal until next reset; reset mid-INIT restarts walk from 0.
//  Writes ignored during INIT (Writeback is quiescent behind reset); in READY, write
//   on clk edge when i_rf_wr=1 and i_rf_rd!=0. Write to x0 dropped, no side effect.
//  Read accept: i_rd_req & o_rf_ready & ~i_stall. Latency 1: next cycle o_rd_vld=1,
//   o_rsN_data = x[i_rsN] sampled at accept edge; rsN==0 -> 0 always.
//  Stall: i_stall=1 holds o_rd_vld and o_rsN_data unchanged; requests not accepted.
//  No accept and no stall: o_rd_vld<=0, data outputs hold last value.
//  Same-cycle write + read of same index (nonzero): see RF_WR_BYPASS_EN.
//  Both read ports may address the same register; both return same value.
//  All arithmetic unsigned; counter ADDR_W+1 bits wide, no wrap in READY.
// CONFIGURATION
//  RF_WR_BYPASS_EN defined: on accepted read where i_rf_wr=1, i_rf_rd==rsN, rsN!=0,
//   o_rsN_data <= i_rf_data (write-first); independent per port.
//  RF_WR_BYPASS_EN undefined: read-first; returns pre-write array value. Decode
//   must then treat a same-cycle writeback as a hazard.
// STRUCTURE
//  Shared defines header: `N, opcode constants (`B, `S, ...), register index width.
//  Sub-module regfile_init_ctrl: INIT/READY FSM + counter; outputs init_we,
//   init_addr, ready. decode_regfile muxes init vs Writeback onto the array write port.
//  Array: reg [DATA_W-1:0] mem[0:2**ADDR_W-1], one write port, two read ports.
// TESTING
//  1 Reset release -> o_rf_ready rises after exactly 32 cycles; reads of x1..x31 = 0.
//  2 Write x5=32'hDEADBEEF, next cycle req rs1=5 rs2=0 -> o_rs1=32'hDEADBEEF, o_rs2=0, o_rd_vld=1.
//  3 Write x0=32'h1234 then read rs1=0 -> 0.
//  4 Write x7=32'hA5A5A5A5 same cycle as req rs1=7,rs2=7 (x7 was 0) -> bypass build:
//     both A5A5A5A5; non-bypass build: both 0, then A5A5A5A5 on re-read.
//  5 Accept read of x3=9, assert i_stall 3 cycles while writing x3=10 -> outputs hold 9,
//     o_rd_vld held 1; after release re-read returns 10.
//  6 Assert rst_n low at init count 12, release -> walk restarts, ready after 32 more cycles.

Source files
------------

// File: rtl/decode_regfile_pkg.sv
// Shared constants for the Decode-side integer register file.
// The optional write-first bypass is selected by the RF_WR_BYPASS_EN macro.
package decode_regfile_pkg;

    localparam int RF_XLEN  = 32;
    localparam int RF_IDX_W = 5;

    localparam logic [0:0] ST_INIT  = 1'b0;
    localparam logic [0:0] ST_READY = 1'b1;

endpackage

// File: rtl/decode_regfile_init_ctrl.sv
// Post-reset init walk: zeroes every register entry once, then reports ready.
// The walk restarts from entry 0 whenever reset is reasserted.
module decode_regfile_init_ctrl
    import decode_regfile_pkg::*;
#(
    parameter int ADDR_W = RF_IDX_W
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              o_init_we,
    output logic [ADDR_W-1:0] o_init_addr,
    output logic              o_ready
);

    localparam logic [ADDR_W:0] LAST_IDX = {1'b0, {ADDR_W{1'b1}}};

    logic [0:0]      r_state;
    logic [ADDR_W:0] r_cnt;
    logic            r_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_INIT;
            r_cnt   <= '0;
            r_ready <= 1'b0;
        end else if (r_state == ST_INIT) begin
            r_cnt <= r_cnt + 1'b1;
            if (r_cnt == LAST_IDX) begin
                r_state <= ST_READY;
                r_ready <= 1'b1;
            end
        end
    end

    assign o_init_we   = (r_state == ST_INIT);
    assign o_init_addr = r_cnt[ADDR_W-1:0];
    assign o_ready     = r_ready;

endmodule

// File: rtl/decode_regfile.sv
// Integer register file: Writeback write port, two registered Decode read ports, x0 = 0.
// Define RF_WR_BYPASS_EN for write-first same-cycle reads; default is read-first.
module decode_regfile
    import decode_regfile_pkg::*;
#(
    parameter int DATA_W = RF_XLEN,
    parameter int ADDR_W = RF_IDX_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_rf_wr,
    input  logic [ADDR_W-1:0] i_rf_rd,
    input  logic [DATA_W-1:0] i_rf_data,
    input  logic              i_rd_req,
    input  logic [ADDR_W-1:0] i_rs1,
    input  logic [ADDR_W-1:0] i_rs2,
    input  logic              i_stall,
    output logic              o_rf_ready,
    output logic              o_rd_vld,
    output logic [DATA_W-1:0] o_rs1_data,
    output logic [DATA_W-1:0] o_rs2_data
);

    logic [DATA_W-1:0] r_mem [0:2**ADDR_W-1];

    logic              w_init_we;
    logic [ADDR_W-1:0] w_init_addr;
    logic              w_ready;
    logic              w_wb_we;
    logic              w_we;
    logic [ADDR_W-1:0] w_waddr;
    logic [DATA_W-1:0] w_wdata;
    logic              w_accept;
    logic [DATA_W-1:0] w_rs1_val;
    logic [DATA_W-1:0] w_rs2_val;

    decode_regfile_init_ctrl #(
        .ADDR_W (ADDR_W)
    ) u_init_ctrl (
        .clk         (clk),
        .rst_n       (rst_n),
        .o_init_we   (w_init_we),
        .o_init_addr (w_init_addr),
        .o_ready     (w_ready)
    );

    // Writeback is only honoured after the walk; x0 writes never reach the array.
    assign w_wb_we = w_ready & i_rf_wr & (i_rf_rd != '0);
    assign w_we    = w_init_we | w_wb_we;
    assign w_waddr = w_init_we ? w_init_addr : i_rf_rd;
    assign w_wdata = w_init_we ? '0 : i_rf_data;

    always_ff @(posedge clk) begin
        if (w_we) begin
            r_mem[w_waddr] <= w_wdata;
        end
    end

    assign w_accept = i_rd_req & w_ready & ~i_stall;

    always_comb begin
        w_rs1_val = r_mem[i_rs1];
        w_rs2_val = r_mem[i_rs2];
`ifdef RF_WR_BYPASS_EN
        if (w_wb_we && (i_rf_rd == i_rs1)) w_rs1_val = i_rf_data;
        if (w_wb_we && (i_rf_rd == i_rs2)) w_rs2_val = i_rf_data;
`endif
        if (i_rs1 == '0) w_rs1_val = '0;
        if (i_rs2 == '0) w_rs2_val = '0;
    end

    // Stall freezes the whole read side; otherwise valid drops while data holds.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_rd_vld   <= 1'b0;
            o_rs1_data <= '0;
            o_rs2_data <= '0;
        end else if (w_accept) begin
            o_rd_vld   <= 1'b1;
            o_rs1_data <= w_rs1_val;
            o_rs2_data <= w_rs2_val;
        end else if (!i_stall) begin
            o_rd_vld   <= 1'b0;
        end
    end

    assign o_rf_ready = w_ready;

endmodule
